// File: rtl/q_mon_pkg.sv
// Shared types and default widths for the q pulse monitor.
// Imported by sat_inc and q_pulse_monitor.
package q_mon_pkg;

  typedef enum logic [1:0] {
    BLOCKED,
    ARMED,
    HIGH
  } q_mon_state_t;

  localparam int COUNT_W_DEF = 8;
  localparam int RUN_W_DEF   = 8;

endpackage

// File: rtl/q_mon_sat_inc.sv
// Saturating incrementer: y = a + 1, held at all-ones.
// Shared by the pulse counter and the run-length counter.
module sat_inc
  import q_mon_pkg::*;
#(
  parameter int W = COUNT_W_DEF
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = (&a) ? a : a + W'(1);

endmodule

// File: rtl/q_pulse_monitor.sv
// Counts and measures high runs of a detector's q output.
// Optional sticky `stuck` output under `Q_MON_STUCK_EN`.
module q_pulse_monitor
  import q_mon_pkg::*;
#(
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int RUN_W     = RUN_W_DEF,
  parameter int THRESHOLD = 4
`ifdef Q_MON_STUCK_EN
  ,
  parameter int TIMEOUT   = 16
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               q,
  input  logic               clear,
  output logic               rise,
  output logic               run_done,
  output logic [RUN_W-1:0]   last_run,
  output logic [RUN_W-1:0]   max_run,
  output logic [COUNT_W-1:0] pulse_count,
`ifdef Q_MON_STUCK_EN
  output logic               stuck,
`endif
  output logic               alarm
);

  localparam logic [COUNT_W-1:0] ALARM_AT =
    COUNT_W'(THRESHOLD - 1);

  q_mon_state_t       state_q, state_d;
  logic               rise_q, rise_d;
  logic               done_q, done_d;
  logic               alarm_q, alarm_d;
  logic [RUN_W-1:0]   last_q, last_d;
  logic [RUN_W-1:0]   max_q, max_d;
  logic [RUN_W-1:0]   run_len_q, run_len_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] count_inc;
  logic [RUN_W-1:0]   run_inc;

  sat_inc #(.W(COUNT_W)) u_count_inc (
    .a (count_q),
    .y (count_inc)
  );

  sat_inc #(.W(RUN_W)) u_run_inc (
    .a (run_len_q),
    .y (run_inc)
  );

  always_comb begin
    state_d   = state_q;
    rise_d    = 1'b0;
    done_d    = 1'b0;
    alarm_d   = alarm_q;
    last_d    = last_q;
    max_d     = max_q;
    run_len_d = run_len_q;
    count_d   = count_q;
    if (clear) begin
      // An interrupted run must not be counted after the clear
      state_d   = q ? BLOCKED : ARMED;
      alarm_d   = 1'b0;
      last_d    = '0;
      max_d     = '0;
      run_len_d = '0;
      count_d   = '0;
    end else begin
      unique case (state_q)
        BLOCKED: begin
          if (!q) state_d = ARMED;
        end
        ARMED: begin
          if (q) begin
            state_d   = HIGH;
            run_len_d = RUN_W'(1);
            count_d   = count_inc;
            rise_d    = 1'b1;
            if (count_q == ALARM_AT) alarm_d = 1'b1;
          end
        end
        HIGH: begin
          if (q) begin
            run_len_d = run_inc;
          end else begin
            state_d = ARMED;
            last_d  = run_len_q;
            done_d  = 1'b1;
            if (run_len_q > max_q) max_d = run_len_q;
          end
        end
        default: state_d = BLOCKED;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= BLOCKED;
      rise_q    <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
      last_q    <= '0;
      max_q     <= '0;
      run_len_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rise_q    <= rise_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
      last_q    <= last_d;
      max_q     <= max_d;
      run_len_q <= run_len_d;
      count_q   <= count_d;
    end
  end

`ifdef Q_MON_STUCK_EN
  logic stuck_q, stuck_d;

  always_comb begin
    stuck_d = stuck_q;
    if (clear) begin
      stuck_d = 1'b0;
    end else if (state_d == HIGH &&
                 32'(run_len_d) == TIMEOUT) begin
      stuck_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) stuck_q <= 1'b0;
    else       stuck_q <= stuck_d;
  end

  assign stuck = stuck_q;
`endif

  assign rise        = rise_q;
  assign run_done    = done_q;
  assign last_run    = last_q;
  assign max_run     = max_q;
  assign pulse_count = count_q;
  assign alarm       = alarm_q;

endmodule

// File: tb/tb_q_pulse_monitor.sv
// Self-checking bench for q_pulse_monitor: vector table,
// directed corner sequences and a history-based random model.
module tb_q_pulse_monitor;
  import q_mon_pkg::*;

  localparam int CW = COUNT_W_DEF;
  localparam int RW = RUN_W_DEF;
  localparam int TH = 4;
  localparam int TO = 16;
  localparam int CMAX = (1 << CW) - 1;
  localparam int RMAX = (1 << RW) - 1;

  logic          clock = 1'b0;
  logic          reset, q, clear;
  logic          rise, run_done, alarm;
  logic [RW-1:0] last_run, max_run;
  logic [CW-1:0] pulse_count;
`ifdef Q_MON_STUCK_EN
  logic          stuck;
`endif

  int checks = 0;
  int errors = 0;
  bit hist[$];

  always #5 clock = ~clock;

  q_pulse_monitor #(
    .COUNT_W   (CW),
    .RUN_W     (RW),
`ifdef Q_MON_STUCK_EN
    .TIMEOUT   (TO),
`endif
    .THRESHOLD (TH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .q           (q),
    .clear       (clear),
    .rise        (rise),
    .run_done    (run_done),
    .last_run    (last_run),
    .max_run     (max_run),
    .pulse_count (pulse_count),
`ifdef Q_MON_STUCK_EN
    .stuck       (stuck),
`endif
    .alarm       (alarm)
  );

  typedef struct {
    bit r, c, qq;
    bit rise, done;
    int last, mx, cnt;
    bit alm;
  } vec_t;

  typedef struct {
    bit rise, done, alm, stk;
    int last, mx, cnt;
  } exp_t;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // History model: the queue holds every q sample since the
  // last reset/clear. A reset seeds a 1 so that a run already
  // high at release looks like it started before history.
  // A run counts only if a 0 precedes it inside history.
  function automatic exp_t model();
    exp_t e;
    int n, i, s, len, raw;
    e.rise = 0; e.done = 0; e.alm = 0; e.stk = 0;
    e.last = 0; e.mx = 0; e.cnt = 0;
    n = hist.size();
    i = 0;
    raw = 0;
    while (i < n) begin
      if (hist[i]) begin
        s = i;
        while (i < n && hist[i]) i++;
        if (s > 0) begin
          len = i - s;
          raw++;
          if (len >= TO) e.stk = 1;
          if (s == n - 1) e.rise = 1;
          if (i < n) begin
            if (len > RMAX) len = RMAX;
            e.last = len;
            if (len > e.mx) e.mx = len;
            if (i == n - 1) e.done = 1;
          end
        end
      end else begin
        i++;
      end
    end
    e.cnt = (raw > CMAX) ? CMAX : raw;
    e.alm = (raw >= TH);
    return e;
  endfunction

  task automatic step(input bit r, input bit c,
                      input bit qq);
    reset = r;
    clear = c;
    q     = qq;
    @(posedge clock);
    #1;
    if (r || c) hist.delete();
    if (r) hist.push_back(1'b1);
    else   hist.push_back(qq);
  endtask

  task automatic check_model(input string tag);
    exp_t e;
    e = model();
    chk({tag, ".rise"}, int'(rise), int'(e.rise));
    chk({tag, ".run_done"}, int'(run_done), int'(e.done));
    chk({tag, ".last_run"}, int'(last_run), e.last);
    chk({tag, ".max_run"}, int'(max_run), e.mx);
    chk({tag, ".pulse_count"}, int'(pulse_count), e.cnt);
    chk({tag, ".alarm"}, int'(alarm), int'(e.alm));
`ifdef Q_MON_STUCK_EN
    chk({tag, ".stuck"}, int'(stuck), int'(e.stk));
`endif
  endtask

  task automatic mstep(input string tag, input bit r,
                       input bit c, input bit qq);
    step(r, c, qq);
    check_model(tag);
  endtask

  task automatic run_pulse(input string tag, input int len);
    for (int k = 0; k < len; k++) mstep(tag, 0, 0, 1);
    mstep(tag, 0, 0, 0);
  endtask

  vec_t tbl[8];

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    q     = 1'b0;

    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 1, 1, 0, 0, 0, 1, 0};
    tbl[4] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[5] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 1, 3, 3, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 3, 3, 1, 0};

    for (int v = 0; v < 8; v++) begin
      step(tbl[v].r, tbl[v].c, tbl[v].qq);
      chk($sformatf("tbl%0d.rise", v), int'(rise),
          int'(tbl[v].rise));
      chk($sformatf("tbl%0d.run_done", v), int'(run_done),
          int'(tbl[v].done));
      chk($sformatf("tbl%0d.last_run", v), int'(last_run),
          tbl[v].last);
      chk($sformatf("tbl%0d.max_run", v), int'(max_run),
          tbl[v].mx);
      chk($sformatf("tbl%0d.pulse_count", v),
          int'(pulse_count), tbl[v].cnt);
      chk($sformatf("tbl%0d.alarm", v), int'(alarm),
          int'(tbl[v].alm));
    end

    // Runs 2,5,1 then a fourth run hits THRESHOLD
    mstep("thr", 1, 0, 0);
    mstep("thr", 0, 0, 0);
    run_pulse("thr", 2);
    run_pulse("thr", 5);
    run_pulse("thr", 1);
    chk("thr.count3", int'(pulse_count), 3);
    chk("thr.last1", int'(last_run), 1);
    chk("thr.max5", int'(max_run), 5);
    chk("thr.alarm0", int'(alarm), 0);
    mstep("thr", 0, 0, 1);
    chk("thr.count4", int'(pulse_count), 4);
    chk("thr.alarm_edge", int'(alarm), 1);
    mstep("thr", 0, 0, 0);
    run_pulse("thr", 3);
    chk("thr.alarm_sticky", int'(alarm), 1);

    // q already high at reset release is not counted
    mstep("blk", 1, 0, 1);
    mstep("blk", 1, 0, 1);
    for (int k = 0; k < 4; k++) mstep("blk", 0, 0, 1);
    mstep("blk", 0, 0, 0);
    chk("blk.no_done", int'(run_done), 0);
    run_pulse("blk", 2);
    chk("blk.count1", int'(pulse_count), 1);
    chk("blk.last2", int'(last_run), 2);

    // clear on the third high sample of a run
    mstep("clr", 0, 0, 1);
    mstep("clr", 0, 0, 0);
    mstep("clr", 0, 0, 1);
    mstep("clr", 0, 0, 1);
    mstep("clr", 0, 1, 1);
    chk("clr.count0", int'(pulse_count), 0);
    chk("clr.max0", int'(max_run), 0);
    chk("clr.alarm0", int'(alarm), 0);
    mstep("clr", 0, 0, 1);
    mstep("clr", 0, 0, 0);
    chk("clr.no_done", int'(run_done), 0);
    run_pulse("clr", 1);
    chk("clr.recount", int'(pulse_count), 1);

    // clear colliding with a run end: no run_done
    mstep("clrend", 0, 0, 1);
    mstep("clrend", 0, 1, 0);
    chk("clrend.no_done", int'(run_done), 0);
    run_pulse("clrend", 2);
    chk("clrend.count1", int'(pulse_count), 1);

    // long run saturates run_len (stuck also sets on the way)
    run_pulse("sat_run", RMAX + 40);
    chk("sat_run.last", int'(last_run), RMAX);

    // clear then overflow the pulse counter
    mstep("sat_cnt", 0, 1, 0);
    for (int k = 0; k < CMAX + 5; k++) run_pulse("sat_cnt", 1);
    chk("sat_cnt.count", int'(pulse_count), CMAX);
    chk("sat_cnt.alarm", int'(alarm), 1);

    // randomized traffic with occasional clear/reset
    mstep("rnd", 0, 1, 0);
    for (int k = 0; k < 2500; k++) begin
      bit nq, nc, nr;
      nq = ($urandom_range(0, 99) < 30) ? ~q : q;
      nc = ($urandom_range(0, 59) == 0);
      nr = ($urandom_range(0, 149) == 0);
      mstep("rnd", nr, nc, nq);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
